// File: rtl/tc_multi.sv
// Multi-channel timer/counter on the device bus: N_CH one-shot/auto-reload/free-run counters.
// Optional per-channel prescaler enabled by defining TC_MULTI_PRESCALE_EN.
module tc_multi #(
   parameter int unsigned N_CH   = 2,
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [ADDR_W-1:0] add_i,
   input  logic              we_i,
   input  logic [31:0]       dat_i,
   output logic [31:0]       dat_o,
   output logic [N_CH-1:0]   irq_o,
   output logic              irq
);

   localparam int unsigned CH_W   = ADDR_W - 2;
   localparam int unsigned CTRL_W = 12;

   logic [CH_W-1:0] ch_idx;
   logic [1:0]      reg_k;
   logic            ch_valid;
   logic [31:0]     rd_data;
   logic            unused_dat;

   logic [N_CH-1:0]            en_a;
   logic [N_CH-1:0]            im_a;
   logic [N_CH-1:0]            pend_a;
   logic [N_CH-1:0][1:0]       mode_a;
   logic [N_CH-1:0][7:0]       ps_a;
   logic [N_CH-1:0][WIDTH-1:0] preset_a;
   logic [N_CH-1:0][WIDTH-1:0] count_a;

   assign ch_idx     = add_i[ADDR_W-1:2];
   assign reg_k      = add_i[1:0];
   assign ch_valid   = (32'(ch_idx) < N_CH);
   assign unused_dat = ^dat_i;

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      logic             sel;
      logic             wr_ctrl;
      logic             wr_preset;
      logic             wr_status;
      logic             tick;
      logic             en_q;
      logic             im_q;
      logic             pend_q;
      logic [1:0]       mode_q;
      logic [WIDTH-1:0] preset_q;
      logic [WIDTH-1:0] count_q;
      logic [WIDTH-1:0] count_nxt;
      logic             pend_set;
      logic             en_clr;

      assign sel       = we_i & ch_valid & (ch_idx == CH_W'(c));
      assign wr_ctrl   = sel & (reg_k == 2'd0);
      assign wr_preset = sel & (reg_k == 2'd1);
      assign wr_status = sel & (reg_k == 2'd3);

`ifdef TC_MULTI_PRESCALE_EN
      logic [7:0] ps_q;
      logic [7:0] div_q;

      assign tick    = en_q & (div_q == ps_q);
      assign ps_a[c] = ps_q;

      // Divider restarts whenever the channel is reprogrammed or idle
      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            ps_q  <= '0;
            div_q <= '0;
         end else begin
            if (wr_ctrl) ps_q <= dat_i[11:4];
            if (!en_q || wr_ctrl || wr_preset || tick) div_q <= '0;
            else                                       div_q <= div_q + 8'd1;
         end
      end
`else
      assign tick    = en_q;
      assign ps_a[c] = '0;
`endif

      // Counter next value and terminal events; a PRESET write overrides the tick
      always_comb begin
         count_nxt = count_q;
         pend_set  = 1'b0;
         en_clr    = 1'b0;
         if (tick) begin
            unique case (mode_q)
               2'd0: begin
                  if (count_q != '0) begin
                     count_nxt = count_q - WIDTH'(1);
                     if (count_q == WIDTH'(1)) begin
                        pend_set = 1'b1;
                        en_clr   = 1'b1;
                     end
                  end
               end
               2'd1: begin
                  if (count_q > WIDTH'(1)) begin
                     count_nxt = count_q - WIDTH'(1);
                  end else begin
                     count_nxt = preset_q;
                     pend_set  = (count_q == WIDTH'(1)) && (preset_q != '0);
                  end
               end
               2'd2: begin
                  count_nxt = count_q + WIDTH'(1);
                  pend_set  = (count_q == '1);
               end
               default: ;
            endcase
         end
         if (wr_preset) begin
            count_nxt = dat_i[WIDTH-1:0];
            pend_set  = 1'b0;
            en_clr    = 1'b0;
         end
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            en_q     <= 1'b0;
            im_q     <= 1'b0;
            mode_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
         end else begin
            count_q <= count_nxt;
            if (wr_preset) preset_q <= dat_i[WIDTH-1:0];
            if (wr_ctrl) begin
               en_q   <= dat_i[0];
               mode_q <= dat_i[2:1];
               im_q   <= dat_i[3];
            end else if (en_clr) begin
               en_q <= 1'b0;
            end
            if (pend_set)                    pend_q <= 1'b1;
            else if (wr_status && dat_i[0])  pend_q <= 1'b0;
         end
      end

      assign en_a[c]     = en_q;
      assign im_a[c]     = im_q;
      assign pend_a[c]   = pend_q;
      assign mode_a[c]   = mode_q;
      assign preset_a[c] = preset_q;
      assign count_a[c]  = count_q;
   end

   // Read mux on pre-edge register values; unmapped channels read 0
   always_comb begin
      rd_data = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (ch_valid && (ch_idx == CH_W'(c))) begin
            unique case (reg_k)
               2'd0: rd_data = 32'(CTRL_W'({ps_a[c], im_a[c], mode_a[c], en_a[c]}));
               2'd1: rd_data = 32'(preset_a[c]);
               2'd2: rd_data = 32'(count_a[c]);
               default: rd_data = 32'(pend_a[c]);
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) dat_o <= '0;
      else          dat_o <= rd_data;
   end

   assign irq_o = pend_a & im_a;
   assign irq   = |irq_o;

endmodule

// File: tb/tb_tc_multi.sv
// Directed bench for tc_multi (N_CH=2, WIDTH=8, ADDR_W=4) against a cycle-level behavioural model.
module tb_tc_multi;

   localparam int unsigned N_CH   = 2;
   localparam int unsigned WIDTH  = 8;
   localparam int unsigned ADDR_W = 4;
   localparam int          MAXV   = (1 << WIDTH) - 1;

   logic              clk_i;
   logic              rst_n_i;
   logic [ADDR_W-1:0] add_i;
   logic              we_i;
   logic [31:0]       dat_i;
   logic [31:0]       dat_o;
   logic [N_CH-1:0]   irq_o;
   logic              irq;

   tc_multi #(.N_CH(N_CH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .add_i  (add_i),
      .we_i   (we_i),
      .dat_i  (dat_i),
      .dat_o  (dat_o),
      .irq_o  (irq_o),
      .irq    (irq)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   logic [31:0]     exp_dat = '0;
   logic [N_CH-1:0] exp_irq = '0;

   // behavioural model state
   int m_en[N_CH], m_mode[N_CH], m_im[N_CH], m_ps[N_CH], m_div[N_CH];
   int m_preset[N_CH], m_count[N_CH], m_pend[N_CH];

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_ps[c] = 0; m_div[c] = 0;
         m_preset[c] = 0; m_count[c] = 0; m_pend[c] = 0;
      end
   endtask

   function automatic logic [31:0] model_read(input int a);
      int ch;
      int k;
      ch = a / 4;
      k  = a % 4;
      if (ch >= N_CH) return 32'd0;
      case (k)
         0: return 32'(m_en[ch] + 2 * m_mode[ch] + 8 * m_im[ch] + 16 * m_ps[ch]);
         1: return 32'(m_preset[ch]);
         2: return 32'(m_count[ch]);
         default: return 32'(m_pend[ch]);
      endcase
   endfunction

   function automatic logic [N_CH-1:0] model_irq();
      logic [N_CH-1:0] r;
      r = '0;
      for (int c = 0; c < N_CH; c++) r[c] = (m_pend[c] != 0) && (m_im[c] != 0);
      return r;
   endfunction

   // One clock edge of the specified behaviour, all rules evaluated on pre-edge state
   task automatic model_step(input bit we, input int a, input logic [31:0] d);
      int ch, k, nc;
      bit wctrl, wpre, wstat, tick, pset, eoff;
      ch = a / 4;
      k  = a % 4;
      for (int c = 0; c < N_CH; c++) begin
         wctrl = we && (ch == c) && (k == 0);
         wpre  = we && (ch == c) && (k == 1);
         wstat = we && (ch == c) && (k == 3);
         tick  = (m_en[c] != 0);
`ifdef TC_MULTI_PRESCALE_EN
         tick = tick && (m_div[c] == m_ps[c]);
         if (m_en[c] == 0 || wctrl || wpre || tick) m_div[c] = 0;
         else                                      m_div[c] = m_div[c] + 1;
`endif
         nc   = m_count[c];
         pset = 1'b0;
         eoff = 1'b0;
         if (tick) begin
            case (m_mode[c])
               0: if (m_count[c] > 0) begin
                     nc = m_count[c] - 1;
                     if (nc == 0) begin pset = 1'b1; eoff = 1'b1; end
                  end
               1: if (m_count[c] == 0)      nc = m_preset[c];
                  else if (m_count[c] == 1) begin nc = m_preset[c]; pset = (m_preset[c] != 0); end
                  else                      nc = m_count[c] - 1;
               2: begin nc = (m_count[c] + 1) % (MAXV + 1); pset = (nc == 0); end
               default: ;
            endcase
         end
         if (wpre) begin
            nc = int'(d) & MAXV;
            m_preset[c] = nc;
            pset = 1'b0;
            eoff = 1'b0;
         end
         m_count[c] = nc;
         if (pset)                    m_pend[c] = 1;
         else if (wstat && d[0])      m_pend[c] = 0;
         if (wctrl) begin
            m_en[c]   = int'(d[0]);
            m_mode[c] = int'(d[2:1]);
            m_im[c]   = int'(d[3]);
`ifdef TC_MULTI_PRESCALE_EN
            m_ps[c]   = int'(d[11:4]);
`endif
         end else if (eoff) begin
            m_en[c] = 0;
         end
      end
   endtask

   // Single compare process: every edge's outputs against the model
   always @(posedge clk_i) begin
      #1;
      if (chk_en) begin
         n_chk++;
         if (dat_o !== exp_dat) begin
            n_err++;
            $display("FAIL dat_o t=%0t got=%h exp=%h", $time, dat_o, exp_dat);
         end
         n_chk++;
         if (irq_o !== exp_irq || irq !== (|exp_irq)) begin
            n_err++;
            $display("FAIL irq t=%0t got irq_o=%b irq=%b exp irq_o=%b", $time, irq_o, irq, exp_irq);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic cycle(input bit we, input int a, input logic [31:0] d);
      we_i    = we;
      add_i   = ADDR_W'(a);
      dat_i   = d;
      exp_dat = model_read(a);
      model_step(we, a, d);
      exp_irq = model_irq();
      @(posedge clk_i);
      #2;
      we_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst_n_i = 1'b0;
      we_i    = 1'b0;
      add_i   = '0;
      dat_i   = '0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #2;
      rst_n_i = 1'b1;
      chk_en  = 1'b1;

      // reset state
      chk("reset_irq", 32'({irq_o, irq}), 32'd0);
      for (int a = 0; a < 8; a++) cycle(1'b0, a, 32'd0);

      // one-shot on ch0
      cycle(1'b1, 1, 32'd5);
      cycle(1'b1, 0, 32'h9);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 2, 32'd0);
         chk("os_count", dat_o, 32'(5 - i));
      end
      chk("os_irq", 32'(irq_o), 32'd1);
      cycle(1'b0, 0, 32'd0);
      cycle(1'b0, 0, 32'd0);
      chk("os_ctrl", dat_o, 32'h8);
      cycle(1'b1, 3, 32'd1);
      chk("os_clear", 32'(irq), 32'd0);

      // auto-reload on ch1, clear colliding with a reload
      cycle(1'b1, 5, 32'd3);
      cycle(1'b1, 4, 32'hB);
      for (int i = 0; i < 3; i++) cycle(1'b0, 6, 32'd0);
      chk("ar_pend1", 32'(irq_o), 32'h2);
      cycle(1'b1, 7, 32'd1);
      chk("ar_cleared", 32'(irq_o), 32'h0);
      cycle(1'b0, 6, 32'd0);
      chk("ar_count2", dat_o, 32'd2);
      cycle(1'b1, 7, 32'd1);
      chk("ar_set_wins", 32'(irq_o), 32'h2);
      cycle(1'b0, 6, 32'd0);
      chk("ar_reload", dat_o, 32'd3);
      cycle(1'b1, 4, 32'd0);
      cycle(1'b1, 7, 32'd1);

      // free-running wrap on ch0, IM enabled afterwards
      cycle(1'b1, 1, 32'hFE);
      cycle(1'b1, 0, 32'h5);
      cycle(1'b0, 2, 32'd0);
      cycle(1'b0, 2, 32'd0);
      chk("fr_ff", dat_o, 32'hFF);
      chk("fr_masked", 32'(irq_o), 32'd0);
      cycle(1'b0, 3, 32'd0);
      chk("fr_pend", dat_o, 32'd1);
      cycle(1'b1, 0, 32'hD);
      chk("fr_irq", 32'(irq), 32'd1);
      cycle(1'b1, 0, 32'd0);
      cycle(1'b1, 3, 32'd1);

      // PRESET write on the terminal edge
      cycle(1'b1, 1, 32'd2);
      cycle(1'b1, 0, 32'd1);
      cycle(1'b0, 2, 32'd0);
      cycle(1'b1, 1, 32'd9);
      cycle(1'b0, 2, 32'd0);
      chk("col_count", dat_o, 32'd9);
      cycle(1'b0, 3, 32'd0);
      chk("col_pend", dat_o, 32'd0);
      cycle(1'b1, 0, 32'd0);

      // unmapped channel
      cycle(1'b1, 8, 32'h1);
      cycle(1'b1, 9, 32'h7);
      cycle(1'b0, 8, 32'd0);
      chk("unmap_ctrl", dat_o, 32'd0);
      cycle(1'b0, 9, 32'd0);
      chk("unmap_preset", dat_o, 32'd0);
      for (int a = 0; a < 8; a++) cycle(1'b0, a, 32'd0);

      // reset in the middle of a count
      cycle(1'b1, 5, 32'd100);
      cycle(1'b1, 4, 32'h9);
      cycle(1'b0, 6, 32'd0);
      cycle(1'b0, 6, 32'd0);
      chk_en = 1'b0;
      #3 rst_n_i = 1'b0;
      #1;
      chk("rst_dat", dat_o, 32'd0);
      chk("rst_irq", 32'({irq_o, irq}), 32'd0);
      model_reset();
      @(posedge clk_i);
      #2;
      rst_n_i = 1'b1;
      chk_en  = 1'b1;
      cycle(1'b0, 6, 32'd0);
      cycle(1'b0, 4, 32'd0);
      chk("rst_count", dat_o, 32'd0);

`ifdef TC_MULTI_PRESCALE_EN
      // prescaler: PS=2 gives one tick every third cycle
      cycle(1'b1, 1, 32'd2);
      cycle(1'b1, 0, 32'h21);
      for (int i = 0; i < 3; i++) cycle(1'b0, 2, 32'd0);
      chk("ps_count_held", dat_o, 32'd2);
      for (int i = 0; i < 3; i++) cycle(1'b0, 2, 32'd0);
      cycle(1'b0, 2, 32'd0);
      chk("ps_count_zero", dat_o, 32'd0);
      cycle(1'b0, 0, 32'd0);
      chk("ps_ctrl", dat_o, 32'h20);
`endif

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/tc_multi.md
Name: tc_multi

Overview:
Parametrised successor to the single timer/counter device on the CPU's device bus. Provides N_CH independent down/up counters behind one word-addressed register window, with one-shot, auto-reload and free-running modes. Each channel has a sticky interrupt-pending bit with write-1-to-clear, per-channel and combined interrupt outputs, and an optional per-channel prescaler. Sits on the device bridge beside other peripherals; the combined irq feeds the CP0 hardware-interrupt input.

Parameters:
N_CH, 2, number of timer channels (1..8)
WIDTH, 32, counter/preset width in bits (8..32); bus values truncated on write, zero-extended on read
ADDR_W, 3, word-address width; must be >= clog2(N_CH)+2

Ports:
clk_i  in  1  system clock, all state on rising edge
rst_n_i  in  1  asynchronous active-low reset
add_i  in  ADDR_W  word address; channel = add_i[ADDR_W-1:2], register = add_i[1:0]
we_i  in  1  write strobe, sampled on rising clk_i
dat_i  in  32  write data
dat_o  out  32  registered read data
irq_o  out  N_CH  per-channel interrupt, irq_o[c] = PEND[c] & IM[c]
irq  out  1  OR of irq_o

Behaviour:
- Register map per channel c, word address c*4+k:
  - k=0 CTRL, RW: [0] EN, [2:1] MODE, [3] IM; other bits read 0.
  - k=1 PRESET, RW.
  - k=2 COUNT, RO; writes ignored.
  - k=3 STATUS: [0] PEND; writing 1 clears it, writing 0 has no effect.
- Channel index >= N_CH: writes ignored, reads return 0.
- Reset (rst_n_i low, async): all CTRL/PRESET/COUNT/PEND = 0, dat_o = 0, irq_o = 0, irq = 0. Reset mid-count aborts the count immediately.
- Read latency 1: dat_o updates on every rising edge with the selected register's value as it was before that edge's updates. No read strobe.
- PRESET write: COUNT loads dat_i[WIDTH-1:0] at the same edge, regardless of EN and MODE.
- A tick is every enabled cycle (see Optional Feature). On a tick with EN=1:
  - MODE 0, one-shot:
    - COUNT!=0: COUNT decrements.
    - 1->0 transition: sets PEND and clears EN.
    - COUNT==0: holds.
  - MODE 1, auto-reload:
    - COUNT>1: COUNT decrements.
    - COUNT==1: COUNT reloads PRESET and sets PEND; period = PRESET ticks.
    - COUNT==0 and PRESET!=0: loads PRESET without setting PEND.
    - PRESET==0: stays 0, never sets PEND.
  - MODE 2, free-running up:
    - COUNT increments.
    - Wrap from all-ones to 0 sets PEND.
  - MODE 3: reserved; counter holds and no PEND.
- Simultaneous events, same edge:
  - PRESET write and tick: the write wins and COUNT = new PRESET; the terminal event from the old value is suppressed.
  - PEND clear and PEND set: set wins.
  - CTRL write and tick: the tick uses the pre-write CTRL.
- irq_o and irq are combinational from PEND/IM registers; irq stays high until software clears PEND or IM.
- Channels are fully independent; no shared state except the bus decode.

Optional Feature:
- Macro: TC_MULTI_PRESCALE_EN.
- Defined:
  - CTRL[11:4] = PS, an 8-bit RW per-channel prescaler.
  - A private 8-bit divider counts clk_i cycles while EN=1; a tick occurs when divider == PS, then the divider returns to 0. The tick rate is clk/(PS+1).
  - The divider clears on reset, on EN=0, and on any CTRL or PRESET write to that channel.
- Undefined:
  - Every cycle with EN=1 is a tick.
  - CTRL[11:4] reads 0 and writes to it are ignored.

Test Plan:
- Reset: deassert rst_n_i, read all 8 words of ch0/ch1 -> all 0; irq=0. Assert rst_n_i low mid-count -> COUNT=0 immediately.
- One-shot: ch0 PRESET=5, CTRL=0b1001 (IM, mode0, EN) -> COUNT 4,3,2,1,0 on 5 consecutive edges; PEND=1 and irq_o[0]=1 at the 0 edge; CTRL reads 0b1000; write STATUS=1 -> irq=0.
- Auto-reload: ch1 PRESET=3, CTRL=0b1011 -> COUNT sequence 2,1,3,2,1,3; PEND set on each reload. Writing STATUS=1 on the same edge as a reload leaves PEND=1.
- Free-run wrap with WIDTH=8: ch0 PRESET=0xFE, CTRL=0b0101 -> 0xFF, 0x00; PEND=1, irq_o[0]=0 (IM=0); then set IM -> irq=1.
- Collision and unmapped: writing PRESET=9 on the edge where COUNT goes 1->0 -> COUNT=9, PEND=0. Write to channel index N_CH -> no effect; read returns 0.
- With TC_MULTI_PRESCALE_EN: PS=2, PRESET=2, mode0 EN -> COUNT decrements every 3rd cycle; reaches 0 after 6 cycles.
